mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits; DW/8 byte lanes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 if_req_valid / if_req_ready  in / out  1  fetch request handshake.
REQ-006 if_addr  input  AW  fetch address.
REQ-007 if_resp_valid / if_rdata  out / out  1 / DW  fetch response.
REQ-008 ls_req_valid / ls_req_ready  in / out  1  load/store request handshake.
REQ-009 ls_addr / ls_wen / ls_wdata / ls_wmask  input  AW / 1 / DW / DW/8  LSU address, write enable, write data, byte mask.
REQ-010 ls_resp_valid / ls_rdata  out / out  1 / DW  LSU response; write acknowledge when ls_wen was 1.
REQ-011 mem_req_valid / mem_req_ready  out / in  1  shared memory-port request handshake.
REQ-012 mem_addr / mem_wen / mem_wdata / mem_wmask  output  AW / 1 / DW / DW/8  latched request fields.
REQ-013 mem_resp_valid / mem_rdata  input  1 / DW  memory response.

Function
REQ-014 FSM states: IDLE, REQ, WAIT; one outstanding transaction max.
REQ-015 IDLE: winner chosen from asserted req_valid; only the winner's req_ready is 1, combinationally, in IDLE only.
REQ-016 Requester handshake (valid & ready) latches addr, wen, wdata, wmask and owner (IF or LS); IF requests latch wen=0, wmask=0. Next state REQ.
REQ-017 REQ: mem_req_valid=1 with latched fields stable until mem_req_ready=1, then WAIT.
REQ-018 WAIT: on mem_resp_valid=1, owner's resp_valid=1 for that cycle, resp_rdata=mem_rdata, next state IDLE; non-owner resp_valid stays 0.
REQ-019 mem_resp_valid outside WAIT is ignored and never forwarded.
REQ-020 Minimum latency: accept at cycle N, mem_req_valid at N+1, response forwarded no earlier than N+2; next accept no earlier than the cycle after the response.
REQ-021 Tie (both valid in IDLE): resolved per REQ-027/REQ-028; the loser's req_ready=0 and the loser holds its request.
REQ-022 No requester valid in IDLE: state remains IDLE, all outputs idle.
REQ-023 Output defaults outside their active state: all req_ready, resp_valid, mem_req_valid and mem_wen are 0; data outputs are don't-care.

Reset
REQ-024 rst=0 forces IDLE immediately, clears latched fields and owner to 0, and deasserts mem_req_valid and both resp_valid.
REQ-025 Reset mid-transaction (REQ or WAIT) drops the transaction; a later mem_resp_valid is ignored per REQ-019.
REQ-026 After reset deassertion, the first accept happens no earlier than the first rising edge with rst=1.

Configuration
REQ-027 Macro MEM_ARB_RR_EN defined: round-robin; a last-owner flop (reset value IF) gives the tie to the requester not granted last; it updates on each accept.
REQ-028 Macro undefined: fixed priority, LSU always wins ties, and no last-owner flop exists.

Structure
REQ-029 Package mem_arb_pkg holds the state enum (IDLE/REQ/WAIT), the owner enum (IF/LS) and the AW/DW defaults.
REQ-030 One sub-module, mem_arb_pick, performs combinational winner selection (inputs: both valids, last owner; output: grant owner); all flops stay in mem_arbiter.

Verification
REQ-031 Fetch only: if_addr=0x80000000 with mem_req_ready=1 and a response one cycle later carrying mem_rdata=0x00000413 -> mem_addr=0x80000000, mem_wen=0, if_resp_valid for 1 cycle with if_rdata=0x00000413, ls_resp_valid=0.
REQ-032 Store: ls_addr=0x80001000, ls_wen=1, ls_wdata=0xDEADBEEF, ls_wmask=0xF -> mem fields match exactly; ls_resp_valid pulses once.
REQ-033 Tie with macro undefined: both valid for 3 transactions -> LS, LS, LS granted and if_req_ready never 1.
REQ-034 Tie with MEM_ARB_RR_EN: both valid held -> grant order LS, IF, LS, IF.
REQ-035 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_addr stable all 5 cycles, and no new accept occurs.
REQ-036 Reset in WAIT: rst=0 for 1 cycle, then mem_resp_valid=1 -> no resp_valid asserted; FSM in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, load/store port and shared memory port.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic            if_req_valid;
  logic            if_req_ready;
  logic [AW-1:0]   if_addr;
  logic            if_resp_valid;
  logic [DW-1:0]   if_rdata;

  logic            ls_req_valid;
  logic            ls_req_ready;
  logic [AW-1:0]   ls_addr;
  logic            ls_wen;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wmask;
  logic            ls_resp_valid;
  logic [DW-1:0]   ls_rdata;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  // Requester/memory side
  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. MEM_ARB_RR_EN selects round-robin ties,
// otherwise the load/store unit always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   ls_valid,
  input  owner_e last_owner,
  output owner_e grant
);

  always_comb begin
    grant = OWN_IF;
    if (if_valid && ls_valid) begin
`ifdef MEM_ARB_RR_EN
      grant = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
`else
      grant = OWN_LS;
`endif
    end else if (ls_valid) begin
      grant = OWN_LS;
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority ignores history.
  logic last_owner_unused;
  assign last_owner_unused = (last_owner == OWN_LS);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one memory port, one
// transaction outstanding. MEM_ARB_RR_EN enables round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  owner_e          grant;
  owner_e          last_owner;
  logic            accept;
  logic            resp_fire;

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;
  assign last_owner = last_q;
`else
  assign last_owner = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_valid   (bus.if_req_valid),
    .ls_valid   (bus.ls_req_valid),
    .last_owner (last_owner),
    .grant      (grant)
  );

  // The winner's ready is high whenever it is valid in IDLE, so any valid accepts.
  assign accept = (state_q == IDLE) && (bus.if_req_valid || bus.ls_req_valid);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          owner_d = grant;
`ifdef MEM_ARB_RR_EN
          last_d  = grant;
`endif
          if (grant == OWN_LS) begin
            addr_d  = bus.ls_addr;
            wen_d   = bus.ls_wen;
            wdata_d = bus.ls_wdata;
            wmask_d = bus.ls_wmask;
          end else begin
            addr_d  = bus.if_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      REQ:     if (bus.mem_req_ready)  state_d = WAIT;
      WAIT:    if (bus.mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.if_req_ready = (state_q == IDLE) && bus.if_req_valid && (grant == OWN_IF);
  assign bus.ls_req_ready = (state_q == IDLE) && bus.ls_req_valid && (grant == OWN_LS);

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = (state_q == REQ) && wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  // Responses only count while a transaction is in WAIT.
  assign resp_fire         = (state_q == WAIT) && bus.mem_resp_valid;
  assign bus.if_resp_valid = resp_fire && (owner_q == OWN_IF);
  assign bus.ls_resp_valid = resp_fire && (owner_q == OWN_LS);
  assign bus.if_rdata      = bus.mem_rdata;
  assign bus.ls_rdata      = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares memory requests and responses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mexp_t;

  mexp_t       mem_q[$];
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      if (mem_q.size() == 0) begin
        chk("mem_req_unexpected", 1, 0);
      end else begin
        mexp_t e;
        e = mem_q.pop_front();
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_wen", bus.mem_wen, e.wen);
        chk("mem_wmask", bus.mem_wmask, e.wmask);
        if (e.wen) chk("mem_wdata", bus.mem_wdata, e.wdata);
      end
    end
    if (bus.if_resp_valid) begin
      if (if_q.size() == 0) chk("if_resp_unexpected", 1, 0);
      else chk("if_rdata", bus.if_rdata, if_q.pop_front());
    end
    if (bus.ls_resp_valid) begin
      if (ls_q.size() == 0) chk("ls_resp_unexpected", 1, 0);
      else chk("ls_rdata", bus.ls_rdata, ls_q.pop_front());
    end
  end

  function automatic mexp_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic [3:0] m);
    mexp_t e;
    e.addr = a; e.wen = w; e.wdata = d; e.wmask = m;
    return e;
  endfunction

  // Called at posedge+1 right after an accept; acts as the memory.
  task automatic serve_mem(input int rsp_dly, input logic [31:0] rdata, output int lat);
    lat = 0;
    while (!bus.mem_req_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat == 20) chk("mem_req_timeout", 0, 1);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    repeat (rsp_dly) begin @(posedge clk); #1; end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = rdata;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic exp_ls;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.if_req_valid = 0; bus.if_addr = '0;
    bus.ls_req_valid = 0; bus.ls_addr = '0; bus.ls_wen = 0; bus.ls_wdata = '0; bus.ls_wmask = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_resp_valid", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
    chk("rst_ready", {bus.if_req_ready, bus.ls_req_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only
    mem_q.push_back(mk(32'h8000_0000, 0, 0, 4'h0));
    if_q.push_back(32'h0000_0413);
    bus.if_addr = 32'h8000_0000; bus.if_req_valid = 1;
    @(negedge clk);
    chk("fetch_if_ready", bus.if_req_ready, 1);
    chk("fetch_ls_ready", bus.ls_req_ready, 0);
    @(posedge clk); #1;
    bus.if_req_valid = 0;
    serve_mem(0, 32'h0000_0413, n);
    chk("fetch_latency", n, 0);
    chk("fetch_if_q_empty", if_q.size(), 0);

    // Store
    mem_q.push_back(mk(32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF));
    ls_q.push_back(32'h0000_0000);
    bus.ls_addr = 32'h8000_1000; bus.ls_wen = 1; bus.ls_wdata = 32'hDEAD_BEEF;
    bus.ls_wmask = 4'hF; bus.ls_req_valid = 1;
    @(negedge clk);
    chk("store_ls_ready", bus.ls_req_ready, 1);
    @(posedge clk); #1;
    bus.ls_req_valid = 0;
    serve_mem(2, 32'h0000_0000, n);
    chk("store_ls_q_empty", ls_q.size(), 0);

    // Backpressure, with a competing fetch and a stray response during REQ
    mem_q.push_back(mk(32'h8000_2000, 0, 0, 4'h3));
    ls_q.push_back(32'hCAFE_0001);
    bus.ls_addr = 32'h8000_2000; bus.ls_wen = 0; bus.ls_wmask = 4'h3; bus.ls_req_valid = 1;
    @(negedge clk);
    chk("bp_ls_ready", bus.ls_req_ready, 1);
    @(posedge clk); #1;
    bus.ls_req_valid = 0;
    bus.if_addr = 32'h8000_0300; bus.if_req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_resp_valid = (i == 2);
      @(negedge clk);
      chk("bp_mem_req_valid", bus.mem_req_valid, 1);
      chk("bp_mem_addr", bus.mem_addr, 32'h8000_2000);
      chk("bp_no_accept", {bus.if_req_ready, bus.ls_req_ready}, 0);
      @(posedge clk); #1;
    end
    bus.mem_resp_valid = 0;
    bus.if_req_valid = 0;
    serve_mem(0, 32'hCAFE_0001, n);
    chk("bp_ls_q_empty", ls_q.size(), 0);

    // Stray response while IDLE
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("idle_resp_ignored", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
    chk("idle_mem_req_valid", bus.mem_req_valid, 0);
    @(posedge clk); #1;
    bus.mem_resp_valid = 0;

    // Reset while in WAIT
    mem_q.push_back(mk(32'h8000_0200, 0, 0, 4'h0));
    bus.if_addr = 32'h8000_0200; bus.if_req_valid = 1;
    @(posedge clk); #1;
    bus.if_req_valid = 0;
    bus.mem_req_ready = 1;
    @(posedge clk); #1;
    bus.mem_req_ready = 0;
    rst = 1'b0;
    #1;
    chk("rstw_mem_req_valid", bus.mem_req_valid, 0);
    chk("rstw_mem_addr", bus.mem_addr, 0);
    chk("rstw_resp_valid", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("rstw_late_resp", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
    @(posedge clk); #1;
    bus.mem_resp_valid = 0;
    bus.if_req_valid = 1;
    @(negedge clk);
    chk("rstw_idle_ready", bus.if_req_ready, 1);
    chk("rstw_idle_mem_valid", bus.mem_req_valid, 0);
    #1;
    bus.if_req_valid = 0;
    @(posedge clk); #1;

    // Tie: both requesters held valid
    bus.if_addr = 32'h8000_0100; bus.if_req_valid = 1;
    bus.ls_addr = 32'h8000_3000; bus.ls_wen = 0; bus.ls_wmask = 4'h0; bus.ls_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_ls = ((i % 2) == 0);
`else
      exp_ls = 1'b1;
`endif
      @(negedge clk);
      chk("tie_ls_ready", bus.ls_req_ready, exp_ls);
      chk("tie_if_ready", bus.if_req_ready, !exp_ls);
      if (exp_ls) begin
        mem_q.push_back(mk(32'h8000_3000, 0, 0, 4'h0));
        ls_q.push_back(32'h0000_1000 + i);
      end else begin
        mem_q.push_back(mk(32'h8000_0100, 0, 0, 4'h0));
        if_q.push_back(32'h0000_1000 + i);
      end
      @(posedge clk); #1;
      serve_mem(1, 32'h0000_1000 + i, n);
    end
    bus.if_req_valid = 0;
    bus.ls_req_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("end_mem_q_empty", mem_q.size(), 0);
    chk("end_if_q_empty", if_q.size(), 0);
    chk("end_ls_q_empty", ls_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
